// File: rtl/ring_inject_pkg.sv
// Shared network definitions for the ring injection path: packet layout,
// node/ID sizing and the head-of-line FSM state type.
package ring_inject_pkg;

  localparam int unsigned NUMNODES   = 16;
  localparam int unsigned ID_SIZE    = $clog2(NUMNODES);
  localparam int unsigned DATA_WIDTH = 16;

  typedef struct packed {
    logic [ID_SIZE-1:0]    src;
    logic [ID_SIZE-1:0]    dest;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    STARVED
  } state_t;

endpackage

// File: rtl/inject_fifo.sv
// In-order packet store for ring_inject: storage array, wrapping pointers,
// occupancy count and a combinational head read.
module inject_fifo
  import ring_inject_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  pkt_t                   wr_data,
  input  logic                   rd_en,
  output pkt_t                   rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  pkt_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !rd_en) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (rd_en && !wr_en) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/ring_inject.sv
// Per-node ring injection queue: stamps core requests with NODE_ID, buffers
// them in order, offers the head to the ring and flags head-of-line starvation.
// Optional statistics counters are built when RING_INJECT_STATS_EN is defined.
module ring_inject
  import ring_inject_pkg::*;
#(
  parameter int unsigned NODE_ID      = 0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_valid,
  output logic                   core_ready,
  input  logic [ID_SIZE-1:0]     core_dest,
  input  logic [DATA_WIDTH-1:0]  core_data,
  output pkt_t                   pkt_out,
  output logic                   pkt_valid,
  input  logic                   ring_accept,
  output logic [$clog2(DEPTH):0] count,
  output logic                   starve,
  output logic [31:0]            sent_count,
  output logic [31:0]            stall_cycles
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

  logic          enq;
  logic          deq;
  pkt_t          wr_pkt;
  pkt_t          head;
  logic [CW-1:0] occ_next;
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d, wait_inc;

  assign core_ready = (count != CW'(DEPTH));
  assign pkt_valid  = (count != '0);
  assign enq        = core_valid && core_ready;
  assign deq        = pkt_valid && ring_accept;
  assign wr_pkt     = '{src: ID_SIZE'(NODE_ID), dest: core_dest, data: core_data};
  assign pkt_out    = pkt_valid ? head : '0;
  assign wait_inc   = wait_q + WW'(1);
  assign starve     = (state_q == STARVED);

  inject_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enq),
    .wr_data (wr_pkt),
    .rd_en   (deq),
    .rd_data (head),
    .count   (count)
  );

  // Occupancy after this edge, used to choose IDLE vs OFFER.
  always_comb begin
    occ_next = count;
    if (enq && !deq) begin
      occ_next = count + CW'(1);
    end else if (deq && !enq) begin
      occ_next = count - CW'(1);
    end
  end

  // Head FSM next-state and wait counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (occ_next != '0) state_d = OFFER;
      end
      OFFER: begin
        if (deq) begin
          wait_d  = '0;
          state_d = (occ_next == '0) ? IDLE : OFFER;
        end else begin
          wait_d = wait_inc;
          if (32'(wait_inc) >= STARVE_LIMIT) state_d = STARVED;
        end
      end
      STARVED: begin
        if (deq) begin
          wait_d  = '0;
          state_d = (occ_next == '0) ? IDLE : OFFER;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Head FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef RING_INJECT_STATS_EN
  logic [31:0] sent_q;
  logic [31:0] stall_q;

  // Saturating injection statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      if (deq && sent_q != '1) sent_q <= sent_q + 32'd1;
      if (pkt_valid && !ring_accept && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign sent_count   = sent_q;
  assign stall_cycles = stall_q;
`else
  assign sent_count   = '0;
  assign stall_cycles = '0;
`endif

endmodule
